// File: rtl/prince_sbox_layer_d2.sv
// Three-share masked PRINCE S-box layer: streams NIBBLES nibbles per state through
// NUM_LANES masked S-box cores, NUM_LANES nibbles per beat, and reassembles the result shares.

module sb_tsm_d2 #(
  parameter int SB_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  i_x0,
  input  logic [3:0]  i_x1,
  input  logic [3:0]  i_x2,
  input  logic [53:0] i_rnd,
  output logic [3:0]  o_y0,
  output logic [3:0]  o_y1,
  output logic [3:0]  o_y2
);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hB;  4'h1: y = 4'hF;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
      4'h4: y = 4'hA;  4'h5: y = 4'hC;  4'h6: y = 4'h9;  4'h7: y = 4'h1;
      4'h8: y = 4'h6;  4'h9: y = 4'h7;  4'hA: y = 4'h8;  4'hB: y = 4'h0;
      4'hC: y = 4'hE;  4'hD: y = 4'h5;  4'hE: y = 4'hD;  4'hF: y = 4'h4;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] fold28(input logic [27:0] v);
    logic [3:0] acc;
    acc = 4'h0;
    for (int k = 0; k < 7; k++) acc = acc ^ v[4*k +: 4];
    return acc;
  endfunction

  logic [3:0] w_m0, w_m1;
  logic [SB_LAT-1:0][3:0] r_p0, r_p1, r_p2;

  assign w_m0 = fold28(i_rnd[27:0]);
  assign w_m1 = fold28({2'b00, i_rnd[53:28]});

  // Behavioural masked core: fresh masks form shares 1 and 2, then SB_LAT-deep pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0 <= '0;
      r_p1 <= '0;
      r_p2 <= '0;
    end else begin
      r_p0[0] <= sbox(i_x0 ^ i_x1 ^ i_x2) ^ w_m0 ^ w_m1;
      r_p1[0] <= w_m0;
      r_p2[0] <= w_m1;
      for (int k = 1; k < SB_LAT; k++) begin
        r_p0[k] <= r_p0[k-1];
        r_p1[k] <= r_p1[k-1];
        r_p2[k] <= r_p2[k-1];
      end
    end
  end

  assign o_y0 = r_p0[SB_LAT-1];
  assign o_y1 = r_p1[SB_LAT-1];
  assign o_y2 = r_p2[SB_LAT-1];

endmodule

module prince_sbox_layer_d2 #(
  parameter int NIBBLES   = 16,
  parameter int NUM_LANES = 1,
  parameter int SB_LAT    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NIBBLES-1:0]    in_sh0,
  input  logic [4*NIBBLES-1:0]    in_sh1,
  input  logic [4*NIBBLES-1:0]    in_sh2,
  input  logic [54*NUM_LANES-1:0] prng,
  output logic                    prng_req,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NIBBLES-1:0]    out_sh0,
  output logic [4*NIBBLES-1:0]    out_sh1,
  output logic [4*NIBBLES-1:0]    out_sh2,
  output logic                    busy
);

  localparam int BEATS = NIBBLES / NUM_LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((NIBBLES % NUM_LANES) != 0) begin : g_bad_lanes
    $error("prince_sbox_layer_d2: NIBBLES must be a multiple of NUM_LANES");
  end
  if (SB_LAT < 1) begin : g_bad_lat
    $error("prince_sbox_layer_d2: SB_LAT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [BW-1:0]             r_beat;
  logic [4*NIBBLES-1:0]      r_st0, r_st1, r_st2;
  logic [4*NIBBLES-1:0]      r_res0, r_res1, r_res2;
  logic [SB_LAT-1:0]         r_dl_vld;
  logic [SB_LAT-1:0][BW-1:0] r_dl_beat;

  logic                         w_feed, w_accept, w_out_hs, w_head_vld, w_last_cap;
  logic [BW-1:0]                w_head_beat;
  logic [54*NUM_LANES-1:0]      w_rnd;
  logic [NUM_LANES-1:0][3:0]    w_lx0, w_lx1, w_lx2, w_ly0, w_ly1, w_ly2;

  assign w_feed      = (r_state == S_FEED);
  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_out_hs    = (r_state == S_DONE) && out_ready;
  assign w_head_vld  = r_dl_vld[SB_LAT-1];
  assign w_head_beat = r_dl_beat[SB_LAT-1];
  assign w_last_cap  = w_head_vld && (w_head_beat == BW'(BEATS-1));
  assign w_rnd       = w_feed ? prng : '0;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_FEED; else w_state_nxt = S_IDLE;
      S_FEED:  if (r_beat == BW'(BEATS-1)) w_state_nxt = S_DRAIN; else w_state_nxt = S_FEED;
      S_DRAIN: if (w_last_cap) w_state_nxt = S_DONE; else w_state_nxt = S_DRAIN;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE; else w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lane input select; zero shares outside FEED
  always_comb begin
    w_lx0 = '0;
    w_lx1 = '0;
    w_lx2 = '0;
    if (w_feed) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        w_lx0[i] = r_st0[4*(int'(r_beat)*NUM_LANES + i) +: 4];
        w_lx1[i] = r_st1[4*(int'(r_beat)*NUM_LANES + i) +: 4];
        w_lx2[i] = r_st2[4*(int'(r_beat)*NUM_LANES + i) +: 4];
      end
    end else begin
      w_lx0 = '0;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sb_tsm_d2 #(.SB_LAT(SB_LAT)) u_sb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_x0  (w_lx0[g]),
      .i_x1  (w_lx1[g]),
      .i_x2  (w_lx2[g]),
      .i_rnd (w_rnd[54*g +: 54]),
      .o_y0  (w_ly0[g]),
      .o_y1  (w_ly1[g]),
      .o_y2  (w_ly2[g])
    );
  end

  // State register, beat counter and beat-tag delay line aligned with the core latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_dl_vld  <= '0;
      r_dl_beat <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_beat <= '0;
      else if (w_feed) r_beat <= r_beat + BW'(1);
      else r_beat <= r_beat;
      r_dl_vld[0]  <= w_feed;
      r_dl_beat[0] <= r_beat;
      for (int k = 1; k < SB_LAT; k++) begin
        r_dl_vld[k]  <= r_dl_vld[k-1];
        r_dl_beat[k] <= r_dl_beat[k-1];
      end
    end
  end

  // Input and result share registers, each share kept in its own register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st0 <= '0;  r_st1 <= '0;  r_st2 <= '0;
      r_res0 <= '0; r_res1 <= '0; r_res2 <= '0;
    end else begin
      if (w_accept) begin
        r_st0 <= in_sh0; r_st1 <= in_sh1; r_st2 <= in_sh2;
      end else if (w_out_hs) begin
        r_st0 <= '0; r_st1 <= '0; r_st2 <= '0;
      end
      if (w_out_hs) begin
        r_res0 <= '0; r_res1 <= '0; r_res2 <= '0;
      end else if (w_head_vld) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          r_res0[4*(int'(w_head_beat)*NUM_LANES + i) +: 4] <= w_ly0[i];
          r_res1[4*(int'(w_head_beat)*NUM_LANES + i) +: 4] <= w_ly1[i];
          r_res2[4*(int'(w_head_beat)*NUM_LANES + i) +: 4] <= w_ly2[i];
        end
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign prng_req  = w_feed;
  assign busy      = (r_state != S_IDLE);
  assign out_sh0   = r_res0;
  assign out_sh1   = r_res1;
  assign out_sh2   = r_res2;

endmodule

// File: tb/tb_prince_sbox_layer_d2.sv
// Bench for prince_sbox_layer_d2: one instance with default lanes and one with four lanes,
// random share splits checked against a per-nibble PRINCE S-box table model.

module tb_prince_sbox_layer_d2;

  localparam logic [3:0] SB [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                     4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  iv, ordy, ir, ov, pr, bz;
  logic [63:0] s0, s1, s2;
  logic [53:0]  prng_a;
  logic [215:0] prng_b;
  logic [63:0] o0 [2];
  logic [63:0] o1 [2];
  logic [63:0] o2 [2];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prince_sbox_layer_d2 u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_sh0(s0), .in_sh1(s1), .in_sh2(s2), .prng(prng_a), .prng_req(pr[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_sh0(o0[0]), .out_sh1(o1[0]), .out_sh2(o2[0]), .busy(bz[0])
  );

  prince_sbox_layer_d2 #(.NIBBLES(16), .NUM_LANES(4), .SB_LAT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_sh0(s0), .in_sh1(s1), .in_sh2(s2), .prng(prng_b), .prng_req(pr[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_sh0(o0[1]), .out_sh1(o1[1]), .out_sh2(o2[1]), .busy(bz[1])
  );

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] sref(input logic [63:0] x);
    logic [63:0] r;
    r = 64'd0;
    for (int k = 0; k < 16; k++) r[4*k +: 4] = SB[x[4*k +: 4]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic split(input logic [63:0] x);
    s0 = rand64();
    s1 = rand64();
    s2 = x ^ s0 ^ s1;
  endtask

  // Present x on DUT sel; returns in the first cycle after the accepting edge
  task automatic start(input int sel, input logic [63:0] x);
    int n;
    n = 0;
    split(x);
    iv[sel] = 1'b1;
    while (!ir[sel] && n < 50) begin tick(); n++; end
    chk("accept_ready", 64'(ir[sel]), 64'd1);
    tick();
    iv[sel] = 1'b0;
    split(rand64());
  endtask

  task automatic wait_done(input int sel, output int cyc, output int np);
    cyc = 1;
    np = 0;
    while (!ov[sel] && cyc < 100) begin
      np += int'(pr[sel]);
      tick();
      cyc++;
    end
  endtask

  task automatic finish_hs(input int sel, input logic [63:0] exp);
    chk("out_value", o0[sel] ^ o1[sel] ^ o2[sel], exp);
    ordy[sel] = 1'b1;
    tick();
    ordy[sel] = 1'b0;
    chk("post_hs_valid", 64'(ov[sel]), 64'd0);
    chk("post_hs_ready", 64'(ir[sel]), 64'd1);
    chk("post_hs_zero", o0[sel] | o1[sel] | o2[sel], 64'd0);
  endtask

  task automatic run(input int sel, input logic [63:0] x, input int lat, input int beats);
    int cyc, np;
    start(sel, x);
    wait_done(sel, cyc, np);
    chk("latency", 64'(cyc), 64'(lat));
    chk("prng_req_cycles", 64'(np), 64'(beats));
    finish_hs(sel, sref(x));
  endtask

  initial begin
    prng_a = '0;
    prng_b = '0;
    forever begin
      @(posedge clk);
      #2;
      prng_a = {$urandom(), $urandom()};
      prng_b = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    end
  end

  initial begin
    logic [63:0] snap0, snap1, snap2, x, xs [4];
    int cyc, np, n, hcyc;
    iv = 2'b00;
    ordy = 2'b00;
    split(rand64());
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 64'(ir[d]), 64'd1);
      chk("rst_out_valid", 64'(ov[d]), 64'd0);
      chk("rst_busy", 64'(bz[d]), 64'd0);
      chk("rst_prng_req", 64'(pr[d]), 64'd0);
      chk("rst_out_sh", o0[d] | o1[d] | o2[d], 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fixed vector, 100 random share splits
    for (int r = 0; r < 100; r++) run(0, 64'h0123456789ABCDEF, 19, 16);
    for (int r = 0; r < 10; r++) run(0, rand64(), 19, 16);

    // Four-lane instance
    run(1, 64'hFFFF0000AAAA5555, 7, 4);
    for (int r = 0; r < 10; r++) run(1, rand64(), 7, 4);

    // Backpressure in DONE, with an in_valid pulse that must be ignored
    x = rand64();
    start(0, x);
    wait_done(0, cyc, np);
    chk("hold_latency", 64'(cyc), 64'd19);
    snap0 = o0[0]; snap1 = o1[0]; snap2 = o2[0];
    for (int i = 0; i < 10; i++) begin
      chk("hold_sh0", o0[0], snap0);
      chk("hold_sh1", o1[0], snap1);
      chk("hold_sh2", o2[0], snap2);
      chk("hold_in_ready", 64'(ir[0]), 64'd0);
      chk("hold_out_valid", 64'(ov[0]), 64'd1);
      iv[0] = (i == 4);
      tick();
    end
    iv[0] = 1'b0;
    finish_hs(0, sref(x));
    chk("hold_no_accept", 64'(bz[0]), 64'd0);

    // Reset pulse at beat 3 of FEED
    start(0, rand64());
    repeat (3) tick();
    chk("pre_rst_busy", 64'(bz[0]), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ready", 64'(ir[0]), 64'd1);
    chk("mid_rst_valid", 64'(ov[0]), 64'd0);
    chk("mid_rst_busy", 64'(bz[0]), 64'd0);
    chk("mid_rst_prng", 64'(pr[0]), 64'd0);
    chk("mid_rst_sh", o0[0] | o1[0] | o2[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run(0, 64'h0123456789ABCDEF, 19, 16);

    // Back-to-back with in_valid and out_ready tied high
    for (int k = 0; k < 4; k++) xs[k] = rand64();
    split(xs[0]);
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    cyc = 0;
    hcyc = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!ir[0] && n < 100) begin tick(); cyc++; n++; end
      chk("b2b_ready", 64'(ir[0]), 64'd1);
      if (k > 0) chk("b2b_accept_gap", 64'(cyc), 64'(hcyc + 1));
      tick();
      cyc++;
      split(xs[k+1]);
      n = 0;
      while (!ov[0] && n < 100) begin tick(); cyc++; n++; end
      chk("b2b_valid", 64'(ov[0]), 64'd1);
      chk("b2b_value", o0[0] ^ o1[0] ^ o2[0], sref(xs[k]));
      hcyc = cyc;
      tick();
      cyc++;
      chk("b2b_pulse", 64'(ov[0]), 64'd0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b0;
    repeat (25) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
